keypad_pin_entry: RTL and testbench
===================================

Name: keypad_pin_entry

Overview:
- Front-end for the parking-gate controller: the producer of the 16-bit BCD PIN that the controller consumes on `password_input`.
- Collects debounced keypad events and assembles four decimal digits, most-significant digit first.
- Supports clear, backspace and enter keys, an inactivity timeout and an alarm lockout.
- Presents the completed PIN with a one-cycle `password_valid` strobe.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in ENTRY, with no accepted key, before the entry is abandoned. Legal range 2..2^20-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- key_valid  input  1  level from keypad scanner; a key event is its 0→1 transition
- key_code  input  4  code sampled on the key_valid rising edge: 0x0-0x9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD-0xF illegal
- sensor_vehicule  input  1  vehicle present at gate; enables entry
- alarm_blocked  input  1  controller lockout; freezes the keypad
- password_input  output  16  last submitted PIN, 4 BCD digits, first typed digit in [15:12]
- password_valid  output  1  one-cycle pulse when password_input is updated
- digit_count  output  3  digits currently buffered (0..4)
- entry_timeout  output  1  one-cycle pulse on inactivity abort
- key_error  output  1  one-cycle pulse on rejected key

Behaviour:
- Reset (async, rst=1) values:
  - all outputs = 0
  - buffer = 0, key_valid edge register = 0, timer = 0
  - state = IDLE
- Key event detection:
  - kev = key_valid & ~key_valid_q, where key_valid_q is registered.
  - Holding key_valid high yields exactly one event.
  - key_code is sampled in the kev cycle.
- State encoding: IDLE, ENTRY, LOCKED.
- Priority each cycle, highest first: alarm_blocked > sensor_vehicule==0 > timeout > kev.
- Any state, alarm_blocked=1:
  - next state LOCKED
  - buffer and digit_count cleared
  - kev ignored, no pulses
- LOCKED → IDLE when alarm_blocked=0.
- IDLE:
  - Keys are ignored silently.
  - sensor_vehicule=1 → ENTRY with buffer=0, count=0, timer=0.
- ENTRY, sensor_vehicule=0 → IDLE; buffer and count cleared.
- ENTRY, digit key:
  - count<4: buffer = {buffer[11:0], digit}, count+1, timer=0.
  - count==4: key_error pulse; buffer unchanged.
- ENTRY, backspace:
  - count>0: buffer = buffer>>4, count-1, timer=0.
  - count==0: key_error pulse.
- ENTRY, clear: buffer=0, count=0, timer=0. Never an error.
- ENTRY, enter:
  - count==4, at the next edge:
    - password_input ← buffer
    - password_valid=1 for exactly one cycle
    - buffer and count cleared, timer=0
    - state stays ENTRY, so a retry needs no re-arm
  - count<4: key_error pulse; buffer kept.
- ENTRY, illegal code 0xD-0xF: key_error pulse, timer unaffected.
- Timeout:
  - timer increments each ENTRY cycle without an accepted key.
  - When timer==TIMEOUT_CYCLES-1:
    - entry_timeout pulses one cycle
    - buffer and count cleared, timer=0
    - state stays ENTRY while sensor_vehicule=1
  - Rejected keys do not reset the timer.
- password_input persistence:
  - Holds its value until the next successful enter or rst.
  - Not cleared by clear, timeout, sensor drop or LOCKED.
- Latency: a kev in cycle n is visible in digit_count and pulse outputs after edge n+1. All outputs are registered.
- Timer width: ceil(log2(TIMEOUT_CYCLES)) bits; it saturates and never wraps.
- rst asserted mid-entry: immediate clear. A key_valid already high at release is not an event until it falls and rises again.

Test Plan:
- Reset then sensor_vehicule=1, keys 3,7,6,1,enter → password_input=0x3761, password_valid high one cycle, digit_count=0.
- Keys 3,7,9,backspace,6,1,enter → 0x3761. Then 5,enter → key_error pulse, digit_count stays 1, password_input still 0x3761.
- Keys 1,2,3,4,5 → fifth key gives a key_error pulse and buffer 0x1234. Then clear, 0,0,0,0,enter → password_input=0x0000 with valid pulse.
- TIMEOUT_CYCLES=8, key 4, then idle 8 cycles → entry_timeout pulse exactly 8 cycles after the accepted key, digit_count=0. Key held high 20 cycles → counted once.
- Mid-entry (count=2) assert alarm_blocked → digit_count=0, keys ignored with no key_error. Deassert → IDLE; with sensor still 1, ENTRY resumes next cycle.
- Mid-entry assert rst for 1 cycle, asynchronous to clk → all outputs 0 immediately, password_input=0. Sensor drop during entry → IDLE, subsequent keys ignored.

Source files
------------

// File: rtl/keypad_pin_entry.sv
// Keypad front-end for the parking-gate controller.
// Turns debounced key events into a 4-digit BCD PIN, most-significant digit first,
// and presents each completed PIN with a one-cycle password_valid strobe.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no vehicle at the gate, keys ignored
// ENTRY  | vehicle present, digits being collected, inactivity timer running
// LOCKED | controller lockout active, keypad frozen
module keypad_pin_entry #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        sensor_vehicule,
    input  logic        alarm_blocked,
    output logic [15:0] password_input,
    output logic        password_valid,
    output logic [2:0]  digit_count,
    output logic        entry_timeout,
    output logic        key_error
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   buffer;
    logic [TW-1:0] timer;
    logic          key_valid_q;

    logic          kev;
    logic          is_digit;
    logic          code_ok;
    logic          key_accept;
    logic          key_reject;

    // Key event decode: decide whether the key in this cycle would be accepted in ENTRY
    always_comb begin
        kev      = key_valid & ~key_valid_q;
        is_digit = (key_code <= 4'd9);
        code_ok  = 1'b0;
        if (is_digit) begin
            code_ok = (digit_count < 3'd4);
        end else if (key_code == KEY_CLEAR) begin
            code_ok = 1'b1;
        end else if (key_code == KEY_BACK) begin
            code_ok = (digit_count != 3'd0);
        end else if (key_code == KEY_ENTER) begin
            code_ok = (digit_count == 3'd4);
        end
        key_accept = kev & code_ok;
        key_reject = kev & ~code_ok;
    end

    // Entry FSM with registered pulse outputs; alarm beats sensor beats timeout beats keys
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            buffer         <= '0;
            timer          <= '0;
            key_valid_q    <= 1'b0;
            password_input <= '0;
            password_valid <= 1'b0;
            digit_count    <= '0;
            entry_timeout  <= 1'b0;
            key_error      <= 1'b0;
        end else begin
            key_valid_q    <= key_valid;
            password_valid <= 1'b0;
            entry_timeout  <= 1'b0;
            key_error      <= 1'b0;

            if (alarm_blocked) begin
                state       <= LOCKED;
                buffer      <= '0;
                digit_count <= '0;
                timer       <= '0;
            end else begin
                case (state)
                    LOCKED: begin
                        state <= IDLE;
                    end

                    IDLE: begin
                        if (sensor_vehicule) begin
                            state       <= ENTRY;
                            buffer      <= '0;
                            digit_count <= '0;
                            timer       <= '0;
                        end
                    end

                    ENTRY: begin
                        if (!sensor_vehicule) begin
                            state       <= IDLE;
                            buffer      <= '0;
                            digit_count <= '0;
                            timer       <= '0;
                        end else if (timer == T_LAST) begin
                            // Timer is cleared here, so it tops out at T_LAST and never wraps
                            entry_timeout <= 1'b1;
                            buffer        <= '0;
                            digit_count   <= '0;
                            timer         <= '0;
                        end else begin
                            timer     <= key_accept ? '0 : timer + TW'(1);
                            key_error <= key_reject;
                            if (key_accept) begin
                                if (is_digit) begin
                                    buffer      <= {buffer[11:0], key_code};
                                    digit_count <= digit_count + 3'd1;
                                end else if (key_code == KEY_CLEAR) begin
                                    buffer      <= '0;
                                    digit_count <= '0;
                                end else if (key_code == KEY_BACK) begin
                                    buffer      <= {4'h0, buffer[15:4]};
                                    digit_count <= digit_count - 3'd1;
                                end else begin
                                    password_input <= buffer;
                                    password_valid <= 1'b1;
                                    buffer         <= '0;
                                    digit_count    <= '0;
                                end
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Directed bench for keypad_pin_entry; pulse outputs are matched against a queue of expected events.
module tb_keypad_pin_entry;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        sensor_vehicule = 1'b0;
    logic        alarm_blocked = 1'b0;
    logic [15:0] password_input;
    logic        password_valid;
    logic [2:0]  digit_count;
    logic        entry_timeout;
    logic        key_error;

    keypad_pin_entry #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .sensor_vehicule (sensor_vehicule),
        .alarm_blocked   (alarm_blocked),
        .password_input  (password_input),
        .password_valid  (password_valid),
        .digit_count     (digit_count),
        .entry_timeout   (entry_timeout),
        .key_error       (key_error)
    );

    always #5 clk = ~clk;

    localparam int EV_VALID = 0;
    localparam int EV_ERROR = 1;
    localparam int EV_TMO   = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic press(input logic [3:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
    endtask

    // Every pulse seen on the outputs must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && (password_valid || key_error || entry_timeout)) begin
            int          kind;
            logic [15:0] val;
            ev_t         e;
            kind = password_valid ? EV_VALID : (key_error ? EV_ERROR : EV_TMO);
            val  = password_valid ? password_input : 16'h0;
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", 32'(kind), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", 32'(kind), 32'(e.kind));
                chk("sb_val", 32'(val), 32'(e.val));
            end
        end
    end

    initial begin
        int edges;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_pin", 32'(password_input), 32'h0);
        chk("rst_valid", 32'(password_valid), 32'h0);
        chk("rst_count", 32'(digit_count), 32'h0);
        chk("rst_tmo", 32'(entry_timeout), 32'h0);
        chk("rst_err", 32'(key_error), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // basic 3761 entry
        sensor_vehicule = 1'b1;
        @(negedge clk);
        press(4'h3); press(4'h7); press(4'h6); press(4'h1);
        chk("count_four", 32'(digit_count), 32'd4);
        expect_ev(EV_VALID, 16'h3761);
        press(4'hC);
        chk("enter_count", 32'(digit_count), 32'd0);
        chk("enter_pin", 32'(password_input), 32'h3761);
        chk("enter_drain", 32'(sb.size()), 32'd0);

        // backspace, then short enter rejected
        press(4'h3); press(4'h7); press(4'h9);
        press(4'hB);
        chk("bksp_count", 32'(digit_count), 32'd2);
        press(4'h6); press(4'h1);
        expect_ev(EV_VALID, 16'h3761);
        press(4'hC);
        press(4'h5);
        expect_ev(EV_ERROR, 16'h0);
        press(4'hC);
        chk("short_enter_count", 32'(digit_count), 32'd1);
        chk("short_enter_pin", 32'(password_input), 32'h3761);

        // clear, backspace on empty, illegal code, fifth digit
        press(4'hA);
        chk("clear_count", 32'(digit_count), 32'd0);
        expect_ev(EV_ERROR, 16'h0);
        press(4'hB);
        expect_ev(EV_ERROR, 16'h0);
        press(4'hD);
        chk("illegal_count", 32'(digit_count), 32'd0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        expect_ev(EV_ERROR, 16'h0);
        press(4'h5);
        chk("fifth_count", 32'(digit_count), 32'd4);
        expect_ev(EV_VALID, 16'h1234);
        press(4'hC);
        chk("fifth_pin", 32'(password_input), 32'h1234);
        press(4'hA);
        press(4'h0); press(4'h0); press(4'h0); press(4'h0);
        expect_ev(EV_VALID, 16'h0000);
        press(4'hC);
        chk("zero_pin", 32'(password_input), 32'h0000);
        chk("zero_drain", 32'(sb.size()), 32'd0);

        // inactivity timeout: eight edges after the key lands
        press(4'h4);
        chk("tmo_pre_count", 32'(digit_count), 32'd1);
        expect_ev(EV_TMO, 16'h0);
        edges = 1;
        while (!entry_timeout && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("tmo_edges", 32'(edges), 32'd8);
        chk("tmo_count", 32'(digit_count), 32'd0);

        // held key counts once
        key_code  = 4'h5;
        key_valid = 1'b1;
        repeat (4) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("held_count", 32'(digit_count), 32'd1);
        press(4'hA);

        // alarm lockout mid-entry
        press(4'h1); press(4'h2);
        chk("pre_alarm_count", 32'(digit_count), 32'd2);
        alarm_blocked = 1'b1;
        @(negedge clk);
        chk("alarm_count", 32'(digit_count), 32'd0);
        press(4'h3);
        press(4'hB);
        chk("alarm_keys_ignored", 32'(digit_count), 32'd0);
        alarm_blocked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        press(4'h9);
        chk("resume_count", 32'(digit_count), 32'd1);
        press(4'h8); press(4'h7); press(4'h6);
        expect_ev(EV_VALID, 16'h9876);
        press(4'hC);
        chk("resume_pin", 32'(password_input), 32'h9876);
        chk("resume_drain", 32'(sb.size()), 32'd0);

        // asynchronous reset mid-entry with key held through release
        press(4'h1); press(4'h2);
        #2;
        rst       = 1'b1;
        key_code  = 4'h5;
        key_valid = 1'b1;
        #1;
        chk("arst_pin", 32'(password_input), 32'h0);
        chk("arst_count", 32'(digit_count), 32'h0);
        chk("arst_pulses", 32'({password_valid, key_error, entry_timeout}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_after_rst", 32'(digit_count), 32'd0);
        chk("pin_after_rst", 32'(password_input), 32'h0);
        key_valid = 1'b0;
        @(negedge clk);
        press(4'h5);
        chk("post_rst_key", 32'(digit_count), 32'd1);

        // sensor drop returns to IDLE and keys are ignored
        sensor_vehicule = 1'b0;
        @(negedge clk);
        chk("drop_count", 32'(digit_count), 32'd0);
        press(4'h7);
        press(4'hC);
        chk("drop_keys_ignored", 32'(digit_count), 32'd0);
        repeat (2) @(negedge clk);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
